// File: rtl/stopwatch_set_controller_pkg.sv
// stopwatch_set_controller_pkg: shared state encoding and digit constants
package stopwatch_set_controller_pkg;
  localparam int DIGIT_WIDTH = 4;
  localparam logic [15:0] DEFAULT_DIGIT_MAX = 16'h5959;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;
endpackage

// File: rtl/stopwatch_set_controller_bcd_digit_stepper.sv
// bcd_digit_stepper: wrap-around increment/decrement of one bounded BCD digit
module bcd_digit_stepper
  import stopwatch_set_controller_pkg::*;
(
  input  logic [DIGIT_WIDTH-1:0] digit,
  input  logic [DIGIT_WIDTH-1:0] max_digit,
  input  logic                   inc,
  input  logic                   dec,
  output logic [DIGIT_WIDTH-1:0] next_digit
);
  // Out-of-range digits snap to 0 on inc and to max on dec
  always_comb
    next_digit = (inc && !dec) ? ((digit >= max_digit) ? '0 : digit + 1'b1) :
                 (dec && !inc) ? ((digit == '0 || digit > max_digit) ? max_digit : digit - 1'b1) :
                 digit;
endmodule

// File: rtl/stopwatch_set_controller.sv
// stopwatch_set_controller: set-mode sequencer that edits BCD digits and commits them via a load strobe
module stopwatch_set_controller
  import stopwatch_set_controller_pkg::*;
#(
  parameter int NUMBER_OF_DIGITS = 4,
  parameter logic [NUMBER_OF_DIGITS*DIGIT_WIDTH-1:0] DIGIT_MAX = DEFAULT_DIGIT_MAX,
  parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                btn_mode,
  input  logic                                btn_next,
  input  logic                                btn_inc,
  input  logic                                btn_dec,
  input  logic                                run_active,
  input  logic [NUMBER_OF_DIGITS*DIGIT_WIDTH-1:0] running_number,
  output logic [NUMBER_OF_DIGITS*DIGIT_WIDTH-1:0] display_number,
  output logic                                set_mode,
  output logic [NUMBER_OF_DIGITS-1:0]         edit_mask,
  output logic [NUMBER_OF_DIGITS*DIGIT_WIDTH-1:0] load_value,
  output logic                                load_strobe,
  output logic                                timeout_abort
);
  localparam int W = NUMBER_OF_DIGITS * DIGIT_WIDTH;
  localparam int IW = NUMBER_OF_DIGITS > 1 ? $clog2(NUMBER_OF_DIGITS) : 1;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUMBER_OF_DIGITS - 1);
  localparam logic [TW-1:0] T_END = TW'(TIMEOUT_CYCLES - 1);
  state_t state, state_nx;
  logic [W-1:0] edit_buf;
  logic [IW-1:0] edit_idx;
  logic [TW-1:0] timer;
  logic any_btn, start, expire;
  logic [DIGIT_WIDTH-1:0] digit_nx;
  assign any_btn = btn_mode | btn_next | btn_inc | btn_dec;
  bcd_digit_stepper u_stepper (
    .digit      (edit_buf[edit_idx*DIGIT_WIDTH +: DIGIT_WIDTH]),
    .max_digit  (DIGIT_MAX[edit_idx*DIGIT_WIDTH +: DIGIT_WIDTH]),
    .inc        (btn_inc),
    .dec        (btn_dec),
    .next_digit (digit_nx)
  );
  always_comb begin
    state_nx = state;
    start = 1'b0;
    expire = 1'b0;
    unique case (state)
      IDLE: begin
        start = btn_mode && !run_active;
        state_nx = start ? EDIT : IDLE;
      end
      EDIT: begin
        expire = !any_btn && timer == T_END;
        state_nx = btn_mode ? COMMIT : expire ? IDLE : EDIT;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      edit_buf <= '0;
      edit_idx <= LAST;
      timer <= '0;
      load_value <= '0;
      timeout_abort <= 1'b0;
    end else begin
      timeout_abort <= expire;
      if (start) begin
        edit_buf <= running_number;
        edit_idx <= LAST;
        timer <= '0;
      end else if (state == EDIT && btn_mode) begin
        load_value <= edit_buf;
        timer <= '0;
      end else if (state == EDIT) begin
        timer <= (any_btn || expire) ? '0 : timer + 1'b1;
        if (btn_next) edit_idx <= (edit_idx == '0) ? LAST : edit_idx - 1'b1;
        else edit_buf[edit_idx*DIGIT_WIDTH +: DIGIT_WIDTH] <= digit_nx;
      end
    end
  end
  assign set_mode = state == EDIT;
  assign load_strobe = state == COMMIT;
  assign edit_mask = set_mode ? NUMBER_OF_DIGITS'(1) << edit_idx : '0;
  assign display_number = (state == IDLE) ? running_number : edit_buf;
endmodule
